// File: rtl/system_tick_pwm.sv
// system_tick_pwm: tick-driven PWM generator behind a 16-bit Avalon-MM register port
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   address[2:0]        register select (0 STATUS, 1 CONTROL, 2 PERIOD, 3 DUTY, 4 COUNT)
//   chipselect, write_n slave select and active-low write strobe
//   writedata[15:0]     write data
//   readdata[15:0]      registered read data, follows address every cycle
//   tick                time-base pulse; the counter advances once per high cycle
//   pwm_out             registered PWM output
//   irq                 level interrupt: period_done && IRQ_EN
module system_tick_pwm #(
    parameter logic [15:0] PERIOD_RESET = 16'd999,
    parameter logic [15:0] DUTY_RESET   = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        tick,
    output logic        pwm_out,
    output logic        irq
);
    logic [15:0] count, period_stg, duty_stg, period_act, duty_act, rd_mux;
    logic [2:0]  ctrl;
    logic        period_done, wr, wr_ctrl, start, stop, boundary, raw;

    assign wr       = chipselect && !write_n;
    assign wr_ctrl  = wr && address == 3'd1;
    // Only a 0->1 RUN transition restarts; rewriting RUN=1 while running is a no-op
    assign start    = wr_ctrl && writedata[1] && !ctrl[1];
    assign stop     = wr_ctrl && !writedata[1];
    assign boundary = ctrl[1] && tick && count == period_act;
    assign raw      = ctrl[1] && count < duty_act;
    assign irq      = period_done && ctrl[0];

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            3'd0:    rd_mux = {14'h0, ctrl[1], period_done};
            3'd1:    rd_mux = {13'h0, ctrl};
            3'd2:    rd_mux = period_stg;
            3'd3:    rd_mux = duty_stg;
            3'd4:    rd_mux = count;
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= 16'h0000;
            period_stg  <= PERIOD_RESET;
            duty_stg    <= DUTY_RESET;
            period_act  <= PERIOD_RESET;
            duty_act    <= DUTY_RESET;
            ctrl        <= 3'b000;
            period_done <= 1'b0;
            pwm_out     <= 1'b0;
            readdata    <= 16'h0000;
        end else begin
            if (wr && address == 3'd2)
                period_stg <= writedata;
            if (wr && address == 3'd3)
                duty_stg <= writedata;
            if (wr_ctrl)
                ctrl <= writedata[2:0];
            // Reloads read the staging registers before this edge's write lands,
            // so a write coinciding with a boundary applies one period later
            if (start) begin
                count      <= 16'h0000;
                period_act <= period_stg;
                duty_act   <= duty_stg;
            end else if (!ctrl[1] || stop) begin
                count <= 16'h0000;
            end else if (boundary) begin
                count      <= 16'h0000;
                period_act <= period_stg;
                duty_act   <= duty_stg;
            end else if (tick) begin
                count <= count + 16'd1;
            end
            // A boundary outranks a simultaneous STATUS clear
            period_done <= boundary || (period_done && !(wr && address == 3'd0));
            pwm_out     <= raw ^ ctrl[2];
            readdata    <= rd_mux;
        end
    end
endmodule

// File: tb/tb_system_tick_pwm.sv
// tb_system_tick_pwm: scoreboard testbench for system_tick_pwm
module tb_system_tick_pwm;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        tick;
    logic        pwm_out;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic        pwm_q[$];
    logic [15:0] v, e;
    logic        pe;

    system_tick_pwm dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .tick(tick), .pwm_out(pwm_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic tk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; tick = tk;
        step();
        chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        d = readdata;
    endtask

    task automatic pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (pwm_out !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL reset_out: pwm=%b irq=%b expected 0 0", pwm_out, irq); end
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back(a == 2 ? 16'h03E7 : 16'h0000);
            rd(a[2:0], v);
            e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL reset_reg%0d: readdata=%h expected=%h", a, v, e); end
        end
    endtask

    task automatic test_basic();
        wr(3'd2, 16'd4, 1'b0);
        wr(3'd3, 16'd2, 1'b0);
        wr(3'd1, 16'h3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            address = 3'd4; chipselect = 1'b1;
            pulse();
            n_cmp++; if (irq !== (i >= 4)) begin n_err++; $display("FAIL basic_irq tick%0d: irq=%b expected=%b", i, irq, i >= 4); end
            exp_q.push_back(16'((i + 1) % 5));
            pwm_q.push_back(((i + 1) % 5) < 2);
            step();
            e = exp_q.pop_front(); pe = pwm_q.pop_front();
            n_cmp++; if (pwm_out !== pe) begin n_err++; $display("FAIL basic_pwm tick%0d: pwm=%b expected=%b", i, pwm_out, pe); end
            n_cmp++; if (readdata !== e) begin n_err++; $display("FAIL basic_count tick%0d: count=%0d expected=%0d", i, readdata, e); end
            step();
        end
        wr(3'd0, 16'h0, 1'b0);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL basic_irq_clear: irq=%b expected=0", irq); end
        exp_q.push_back(16'h0002); rd(3'd0, v); e = exp_q.pop_front();
        n_cmp++; if (v !== e) begin n_err++; $display("FAIL basic_status: readdata=%h expected=%h", v, e); end
    endtask

    task automatic test_double_buffer();
        wr(3'd1, 16'h0, 1'b0);
        wr(3'd2, 16'd9, 1'b0);
        wr(3'd3, 16'd2, 1'b0);
        wr(3'd1, 16'h3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            address = 3'd4; chipselect = 1'b1;
            pulse();
            exp_q.push_back(16'((i + 1) % 10));
            pwm_q.push_back(((i + 1) % 10) < (i >= 9 ? 7 : 2));
            step();
            e = exp_q.pop_front(); pe = pwm_q.pop_front();
            n_cmp++; if (pwm_out !== pe) begin n_err++; $display("FAIL dbuf_pwm tick%0d: pwm=%b expected=%b", i, pwm_out, pe); end
            n_cmp++; if (readdata !== e || readdata > 16'd9) begin n_err++; $display("FAIL dbuf_count tick%0d: count=%0d expected=%0d", i, readdata, e); end
            if (i == 2) wr(3'd3, 16'd7, 1'b0);
            else step();
        end
    endtask

    task automatic test_extremes();
        logic [15:0] per [4] = '{16'd4, 16'd4, 16'hFFFE, 16'hFFFE};
        logic [15:0] dty [4] = '{16'd0, 16'd0, 16'hFFFF, 16'hFFFF};
        logic [15:0] ctl [4] = '{16'h2, 16'h6, 16'h2, 16'h6};
        logic        lvl [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            wr(3'd1, 16'h0, 1'b0);
            wr(3'd2, per[c], 1'b0);
            wr(3'd3, dty[c], 1'b0);
            wr(3'd1, ctl[c], 1'b0);
            for (int i = 0; i < 6; i++) begin
                pulse();
                pwm_q.push_back(lvl[c]);
                step();
                pe = pwm_q.pop_front();
                n_cmp++; if (pwm_out !== pe) begin n_err++; $display("FAIL extreme%0d_pwm tick%0d: pwm=%b expected=%b", c, i, pwm_out, pe); end
            end
        end
        wr(3'd1, 16'h0, 1'b0);
        wr(3'd2, 16'd0, 1'b0);
        wr(3'd1, 16'h3, 1'b0);
        wr(3'd0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h0002); rd(3'd0, v); e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL p0_clear%0d: status=%h expected=%h", i, v, e); end
            pulse();
            n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL p0_irq%0d: irq=%b expected=1", i, irq); end
            exp_q.push_back(16'h0003); rd(3'd0, v); e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL p0_done%0d: status=%h expected=%h", i, v, e); end
            exp_q.push_back(16'h0000); rd(3'd4, v); e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL p0_count%0d: count=%h expected=%h", i, v, e); end
            wr(3'd0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] cnt_exp [3] = '{16'd0, 16'd0, 16'd1};
        wr(3'd0, 16'h0, 1'b1);
        exp_q.push_back(16'h0003); rd(3'd0, v); e = exp_q.pop_front();
        n_cmp++; if (v !== e) begin n_err++; $display("FAIL sim_clear_vs_set: status=%h expected=%h", v, e); end
        wr(3'd2, 16'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) pulse();
            exp_q.push_back(cnt_exp[i]); rd(3'd4, v); e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL sim_reload%0d: count=%0d expected=%0d", i, v, e); end
        end
        pulse();
        wr(3'd1, 16'h3, 1'b0);
        exp_q.push_back(16'd2); rd(3'd4, v); e = exp_q.pop_front();
        n_cmp++; if (v !== e) begin n_err++; $display("FAIL sim_no_restart: count=%0d expected=%0d", v, e); end
    endtask

    task automatic test_stop_reset();
        wr(3'd1, 16'h4, 1'b0);
        exp_q.push_back(16'd0); rd(3'd4, v); e = exp_q.pop_front();
        n_cmp++; if (v !== e) begin n_err++; $display("FAIL stop_count: count=%0d expected=%0d", v, e); end
        n_cmp++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL stop_pwm: pwm=%b expected=1", pwm_out); end
        for (int i = 0; i < 3; i++) begin
            pulse();
            exp_q.push_back(16'd0); rd(3'd4, v); e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL stop_idle%0d: count=%0d expected=%0d", i, v, e); end
        end
        exp_q.push_back(16'h0001); rd(3'd0, v); e = exp_q.pop_front();
        n_cmp++; if (v !== e) begin n_err++; $display("FAIL stop_status: status=%h expected=%h", v, e); end
        wr(3'd3, 16'd2, 1'b0);
        wr(3'd1, 16'h7, 1'b0);
        pulse();
        pulse();
        address = 3'd4; chipselect = 1'b1;
        step();
        n_cmp++; if (readdata !== 16'd2 || pwm_out !== 1'b1 || irq !== 1'b1) begin n_err++; $display("FAIL pre_reset: count=%0d pwm=%b irq=%b expected 2 1 1", readdata, pwm_out, irq); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (pwm_out !== 1'b0 || irq !== 1'b0 || readdata !== 16'h0) begin n_err++; $display("FAIL mid_reset: pwm=%b irq=%b readdata=%h expected 0 0 0", pwm_out, irq, readdata); end
        for (int a = 0; a < 5; a++) begin
            exp_q.push_back(a == 2 ? 16'h03E7 : 16'h0000);
            rd(a[2:0], v);
            e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL post_reset_reg%0d: readdata=%h expected=%h", a, v, e); end
        end
    endtask

    initial begin
        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 16'h0; tick = 1'b0;
        step();
        test_reset();
        test_basic();
        test_double_buffer();
        test_extremes();
        test_simultaneous();
        test_stop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
